// File: rtl/mul_seq.sv
// mul_seq: sequential shift-add multiplier producing a full 2*WIDTH product.
// Operands are reduced to magnitudes on acceptance, multiplied one multiplier
// bit per cycle (LSB first), and the sign is restored in a final FIX cycle
// that also updates the Z/N/C/V flags and pulses done.
module mul_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             sign,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] product_hi,
    output logic [WIDTH-1:0] product_lo,
    output logic             Z,
    output logic             N,
    output logic             C,
    output logic             V
);

    localparam int PW    = 2 * WIDTH;
    localparam int CNT_W = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;

    logic [PW-1:0]    mcand;
    logic [WIDTH-1:0] mplier;
    logic [PW-1:0]    acc;
    logic             neg;
    logic             sign_r;

    logic             accept;
    logic             last_iter;
    logic [PW-1:0]    result;
    logic [WIDTH-1:0] result_hi;
    logic [WIDTH-1:0] result_lo;

    // Magnitude of an operand; the most negative value maps to 2^(WIDTH-1)
    // because the result is interpreted as unsigned.
    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] x,
                                                   input logic             s);
        return (s && x[WIDTH-1]) ? (~x + WIDTH'(1)) : x;
    endfunction

    // Conditional two's-complement negation of the full-width product.
    function automatic logic [PW-1:0] apply_sign(input logic [PW-1:0] x,
                                                 input logic          n);
        return n ? (~x + PW'(1)) : x;
    endfunction

    assign accept    = (state == IDLE) && start;
    assign last_iter = (cnt == CNT_W'(WIDTH - 1));
    assign busy      = (state != IDLE);
    assign result    = apply_sign(acc, neg);
    assign result_hi = result[PW-1:WIDTH];
    assign result_lo = result[WIDTH-1:0];

    // State register; reset aborts any operation immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: accept in IDLE, iterate WIDTH times, then one FIX cycle.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (last_iter) state_nxt = FIX;
            FIX:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Iteration counter: cleared on accept, advanced once per RUN cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (accept) begin
            cnt <= '0;
        end else if (state == RUN) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    // Datapath: capture magnitudes on accept, then shift-add one bit per cycle.
    always_ff @(posedge clk) begin
        if (accept) begin
            mcand  <= {{WIDTH{1'b0}}, magnitude(A, sign)};
            mplier <= magnitude(B, sign);
            acc    <= '0;
            neg    <= sign & (A[WIDTH-1] ^ B[WIDTH-1]);
            sign_r <= sign;
        end else if (state == RUN) begin
            if (mplier[0]) begin
                acc <= acc + mcand;
            end
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
        end
    end

    // Result, flags and done pulse; outputs hold until the next FIX cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            done       <= 1'b0;
            product_hi <= '0;
            product_lo <= '0;
            Z          <= 1'b0;
            N          <= 1'b0;
            C          <= 1'b0;
            V          <= 1'b0;
        end else begin
            done <= 1'b0;
            if (state == FIX) begin
                done       <= 1'b1;
                product_hi <= result_hi;
                product_lo <= result_lo;
                Z          <= (result == '0);
                N          <= sign_r & result[PW-1];
                C          <= ~sign_r & (result_hi != '0);
                V          <= sign_r & (result_hi != {WIDTH{result_lo[WIDTH-1]}});
            end
        end
    end

endmodule
